inst_axi_rd_bridge: RTL and testbench
=====================================

Name: inst_axi_rd_bridge

Overview:
- Sits between the fetch stage's SRAM-like instruction port and the core's AXI read channels (AR/R).
- Accepts one single-word instruction read at a time and translates the MIPS kseg0/kseg1 virtual address to a physical address.
- Issues a single-beat AXI read and returns the word through the SRAM-like data_ok handshake.
- Supports discarding the in-flight result when fetch is flushed.

Parameters:
- ARID_VAL, 4'd0, constant arid driven on every request
- ID_W, 4, width of arid/rid

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- inst_req  in  1  fetch request
- inst_wr  in  1  write flag; must be 0, writes never accepted
- inst_size  in  2  log2 bytes (2'b10 = word)
- inst_addr  in  32  virtual fetch address
- inst_wdata  in  32  unused, ignored
- inst_cancel  in  1  flush: drop result of the outstanding fetch
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  inst_rdata valid this cycle
- inst_rdata  out  32  fetched word
- arid  out  ID_W  = ARID_VAL
- araddr  out  32  physical address
- arlen  out  8  = 0
- arsize  out  3  = {1'b0, captured inst_size}
- arburst  out  2  = 2'b01
- arlock  out  2  = 0
- arcache  out  4  = 0
- arprot  out  3  = 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  ID_W  ignored
- rdata  in  32  read data
- rresp  in  2  response
- rlast  in  1  ignored (single beat)
- rvalid  in  1  R valid
- rready  out  1  R ready
- inst_bus_err  out  1  error pulse (feature-dependent)

Behaviour:
- State machine has three states: IDLE, ADDR, DATA. An internal 1-bit drop flag is also held.
- Reset, asynchronous:
  - state=IDLE, drop=0, arvalid=0, rready=0, araddr=0, arsize=0.
  - inst_addr_ok=0, inst_data_ok=0, inst_bus_err=0.
  - Any in-flight transaction is abandoned; the interconnect shares the same reset.
- inst_addr_ok = (state==IDLE) & inst_req & ~inst_wr & ~inst_cancel. This is combinational and takes zero cycles.
- On an addr_ok cycle:
  - Capture araddr = translate(inst_addr) and arsize.
  - Set drop=0 and go to ADDR.
- translate(a):
  - If a[31:30]==2'b10 (kseg0/kseg1), result = {3'b000, a[28:0]}.
  - Otherwise a passes through unchanged.
  - Example: 0xbfc0_0000 -> 0x1fc0_0000; 0x9fc0_0004 -> 0x1fc0_0004.
- ADDR state:
  - arvalid=1, and araddr is held stable until arready.
  - On arready, go to DATA; arvalid deasserts in the next cycle.
- DATA state:
  - rready=1.
  - On rvalid: inst_data_ok = ~drop and inst_rdata = rdata (combinational pass-through), then go to IDLE.
- Minimum latency: request at cycle N gives arvalid at N+1; with arready=1 and rvalid at N+2, data_ok is at N+2.
- Only one outstanding transaction. inst_addr_ok=0 in ADDR and DATA even while inst_req is held.
- inst_cancel:
  - In ADDR or DATA (or the DATA cycle where rvalid arrives): sets drop=1. The AXI transaction still completes and its inst_data_ok is suppressed.
  - In IDLE: blocks acceptance for that cycle only.
- inst_wr=1: never accepted; addr_ok stays 0.
- inst_rdata is 32'b0 whenever inst_data_ok=0.
- No new request can be accepted in the same cycle as the R handshake; next acceptance is in the following IDLE cycle.

Optional Feature:
- Macro INST_AXI_ERR_EN.
- Defined:
  - On the R handshake with rresp[1]==1 (SLVERR/DECERR) and drop=0, inst_bus_err pulses with inst_data_ok.
  - inst_rdata is forced to 32'h0000_0000 (nop) on that pulse.
- Undefined:
  - rresp is ignored and inst_bus_err is tied 0.

Decomposition:
- Package cpu_axi_pkg holds:
  - AXI constants: AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - Bridge state enum: IDLE, ADDR, DATA.
  - Function kseg_translate(addr[31:0]); it is reused by the data-side bridge.
- No sub-module; a single FSM file.

Test Plan:
- Reset checks:
  - Stimulus: assert rst mid-DATA.
  - Required: arvalid=0, rready=0, addr_ok=0, data_ok=0 immediately, without waiting for a clk edge; the first request after release is accepted normally.
- Single fetch:
  - Stimulus: inst_req with addr 0xbfc0_0000, arready=1, rvalid one cycle later with rdata=0x3c08_bfc0.
  - Required: araddr=0x1fc0_0000, arsize=3'b010, arlen=0; inst_data_ok=1 with inst_rdata=0x3c08_bfc0 for exactly 1 cycle.
- Backpressure:
  - Stimulus: arready held low 3 cycles, then rvalid delayed 4 cycles; inst_req held continuously.
  - Required: araddr stable throughout and addr_ok=0 until return to IDLE; exactly one data_ok.
- Back-to-back fetches:
  - Stimulus: continuous fetches at 0xbfc0_0000, 0x…04, 0x…08.
  - Required: three AR handshakes in order, three data_ok pulses with matching data, and never two outstanding.
- Cancel:
  - Stimulus: inst_cancel pulsed in DATA before rvalid.
  - Required: R handshake still completes (rready=1), inst_data_ok stays 0; the next request is accepted and returns data normally.
- Bus error (INST_AXI_ERR_EN defined):
  - Stimulus: rresp=2'b10.
  - Required: inst_bus_err=1 and inst_data_ok=1 with inst_rdata=0.
  - Without the macro: inst_bus_err stays 0 and inst_rdata=rdata.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// cpu_axi_pkg: shared definitions for the core's AXI bridges.
//   - AXI burst/response encodings used by the instruction and data bridges
//   - bridge_state_e: three-state single-outstanding bridge FSM encoding
//   - kseg_translate(): MIPS kseg0/kseg1 virtual-to-physical mapping
package cpu_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } bridge_state_e;

  // kseg0 (0x8000_0000) and kseg1 (0xa000_0000) both alias the low 512 MB
  // of physical memory; every other segment is mapped one-to-one here.
  function automatic logic [31:0] kseg_translate(input logic [31:0] addr);
    if (addr[31:30] == 2'b10) begin
      return {3'b000, addr[28:0]};
    end
    return addr;
  endfunction

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: SRAM-like instruction fetch port to AXI read (AR/R).
//
// One single-beat read outstanding at a time. The fetch address is
// translated (kseg0/kseg1 -> physical) and captured on acceptance.
//
// Handshakes: an AXI channel transfers on a cycle where valid and ready are
// both high; valid, once raised, stays high with stable payload until that
// transfer. On the SRAM-like side, inst_addr_ok is the accept strobe for the
// request presented in the same cycle, and inst_data_ok marks inst_rdata
// valid for exactly that cycle (inst_rdata is zero otherwise).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   inst_req/wr/size/addr/wdata/cancel   fetch request side (wdata ignored)
//   inst_addr_ok, inst_data_ok, inst_rdata   fetch response side
//   arid..arvalid, arready                AXI read address channel
//   rid, rdata, rresp, rlast, rvalid, rready  AXI read data channel
//   inst_bus_err        error pulse alongside inst_data_ok
//
// Build option: define INST_AXI_ERR_EN to report SLVERR/DECERR responses on
// inst_bus_err (with the returned word forced to a nop). Without it, rresp is
// ignored and inst_bus_err is tied low.
module inst_axi_rd_bridge
  import cpu_axi_pkg::*;
#(
  parameter int              ID_W     = 4,
  parameter logic [ID_W-1:0] ARID_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic            inst_wr,
  input  logic [1:0]      inst_size,
  input  logic [31:0]     inst_addr,
  input  logic [31:0]     inst_wdata,
  input  logic            inst_cancel,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [31:0]     inst_rdata,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic            inst_bus_err
);

  bridge_state_e state;
  logic          drop;     // result of the outstanding read is to be discarded
  logic          r_fire;   // R handshake this cycle
  logic          deliver;  // R handshake whose result goes back to fetch
  logic          err_hit;

  // Constant AR attributes: single-beat incrementing, normal access.
  assign arid    = ARID_VAL;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // rst gating keeps the accept strobe low during reset without a clock.
  assign inst_addr_ok = ~rst & (state == IDLE) & inst_req & ~inst_wr & ~inst_cancel;

  assign r_fire  = (state == DATA) & rready & rvalid;
  // A cancel arriving in the same cycle as the response also discards it.
  assign deliver = r_fire & ~drop & ~inst_cancel;

`ifdef INST_AXI_ERR_EN
  assign err_hit = deliver & rresp[1];
`else
  assign err_hit = 1'b0;
`endif

  assign inst_data_ok = deliver;
  assign inst_bus_err = err_hit;
  assign inst_rdata   = (deliver & ~err_hit) ? rdata : 32'h0000_0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      drop    <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      araddr  <= 32'h0000_0000;
      arsize  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (inst_addr_ok) begin
            araddr  <= kseg_translate(inst_addr);
            arsize  <= {1'b0, inst_size};
            drop    <= 1'b0;
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (inst_cancel) drop <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (inst_cancel) drop <= 1'b1;
          if (rvalid) begin
            rready <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          arvalid <= 1'b0;
          rready  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Inputs that carry no information for a single-beat, fixed-ID read.
  logic unused_inputs;
  assign unused_inputs = ^{inst_wdata, rid, rlast, rresp};

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed testbench for inst_axi_rd_bridge. Inputs change 1 ns after the
// rising edge; outputs are checked in the settled part of the cycle.
module tb_inst_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0, inst_wr = 1'b0, inst_cancel = 1'b0;
  logic [1:0]  inst_size = 2'b10;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic        inst_addr_ok, inst_data_ok, inst_bus_err;
  logic [31:0] inst_rdata;
  logic [3:0]  arid, rid = 4'h0;
  logic [31:0] araddr, rdata = '0;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock, rresp = 2'b00;
  logic [3:0]  arcache;
  logic        arvalid, arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_axi_rd_bridge #(.ID_W(4), .ARID_VAL(4'd0)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .inst_bus_err(inst_bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch. Starts in an IDLE cycle, ends 1 ns after the edge
  // that returns the bridge to IDLE. hold keeps inst_req high throughout;
  // cancel_data pulses inst_cancel on the first DATA wait cycle.
  task automatic fetch(input string tag, input logic [31:0] va, input logic [31:0] pa,
                       input logic [31:0] word, input int ar_wait, input int r_wait,
                       input logic [1:0] resp, input bit hold, input bit cancel_data,
                       input logic exp_ok, input logic exp_err, input logic [31:0] exp_rd);
    inst_req  = 1'b1;
    inst_addr = va;
    #1;
    check({tag, ".addr_ok"}, {31'b0, inst_addr_ok}, 32'd1);
    step();
    inst_req = hold;
    check({tag, ".araddr"}, araddr, pa);
    check({tag, ".arsize"}, {29'b0, arsize}, 32'd2);
    check({tag, ".arlen"}, {24'b0, arlen}, 32'd0);
    for (int i = 0; i < ar_wait; i++) begin
      check({tag, ".arvalid_wait"}, {31'b0, arvalid}, 32'd1);
      check({tag, ".araddr_hold"}, araddr, pa);
      check({tag, ".addr_ok_busy"}, {31'b0, inst_addr_ok}, 32'd0);
      step();
    end
    check({tag, ".arvalid"}, {31'b0, arvalid}, 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check({tag, ".arvalid_drop"}, {31'b0, arvalid}, 32'd0);
    for (int i = 0; i < r_wait; i++) begin
      inst_cancel = cancel_data && (i == 0);
      #1;
      check({tag, ".rready_wait"}, {31'b0, rready}, 32'd1);
      check({tag, ".data_ok_wait"}, {31'b0, inst_data_ok}, 32'd0);
      check({tag, ".addr_ok_data"}, {31'b0, inst_addr_ok}, 32'd0);
      step();
      inst_cancel = 1'b0;
    end
    rvalid = 1'b1;
    rdata  = word;
    rresp  = resp;
    #1;
    check({tag, ".rready"}, {31'b0, rready}, 32'd1);
    check({tag, ".data_ok"}, {31'b0, inst_data_ok}, {31'b0, exp_ok});
    check({tag, ".rdata"}, inst_rdata, exp_rd);
    check({tag, ".bus_err"}, {31'b0, inst_bus_err}, {31'b0, exp_err});
    check({tag, ".addr_ok_rhs"}, {31'b0, inst_addr_ok}, 32'd0);
    step();
    rvalid = 1'b0;
    rresp  = 2'b00;
    #1;
    check({tag, ".data_ok_once"}, {31'b0, inst_data_ok}, 32'd0);
    check({tag, ".rdata_zero"}, inst_rdata, 32'd0);
    check({tag, ".rready_drop"}, {31'b0, rready}, 32'd0);
    if (hold) begin
      check({tag, ".addr_ok_again"}, {31'b0, inst_addr_ok}, 32'd1);
      inst_req = 1'b0;
      #1;
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst.arvalid", {31'b0, arvalid}, 32'd0);
    check("rst.rready", {31'b0, rready}, 32'd0);
    check("rst.araddr", araddr, 32'd0);
    check("rst.bus_err", {31'b0, inst_bus_err}, 32'd0);
    check("rst.arid", {28'b0, arid}, 32'd0);
    check("rst.arburst", {30'b0, arburst}, 32'd1);
    step();
    step();
    rst = 1'b0;
    step();

    // Single fetch, minimum latency
    fetch("single", 32'hbfc0_0000, 32'h1fc0_0000, 32'h3c08_bfc0, 0, 0, 2'b00, 0, 0,
          1'b1, 1'b0, 32'h3c08_bfc0);

    // Backpressure on both channels, request held high throughout
    fetch("bp", 32'h9fc0_0004, 32'h1fc0_0004, 32'h2508_0010, 3, 4, 2'b00, 1, 0,
          1'b1, 1'b0, 32'h2508_0010);
    step();

    // Back-to-back fetches, each accepted in the IDLE cycle after the last
    fetch("b2b0", 32'hbfc0_0000, 32'h1fc0_0000, 32'h1111_0000, 0, 0, 2'b00, 0, 0,
          1'b1, 1'b0, 32'h1111_0000);
    fetch("b2b1", 32'hbfc0_0004, 32'h1fc0_0004, 32'h2222_0004, 0, 0, 2'b00, 0, 0,
          1'b1, 1'b0, 32'h2222_0004);
    fetch("b2b2", 32'hbfc0_0008, 32'h1fc0_0008, 32'h3333_0008, 0, 0, 2'b00, 0, 0,
          1'b1, 1'b0, 32'h3333_0008);

    // Untranslated segments pass through
    fetch("useg", 32'h0040_1000, 32'h0040_1000, 32'h0000_0001, 1, 0, 2'b00, 0, 0,
          1'b1, 1'b0, 32'h0000_0001);
    fetch("kseg2", 32'hc000_0010, 32'hc000_0010, 32'h0000_0002, 0, 1, 2'b00, 0, 0,
          1'b1, 1'b0, 32'h0000_0002);

    // Cancel while waiting in DATA: response consumed but not delivered
    fetch("cancel", 32'hbfc0_0100, 32'h1fc0_0100, 32'hdead_beef, 0, 2, 2'b00, 0, 1,
          1'b0, 1'b0, 32'h0000_0000);
    fetch("after_cancel", 32'hbfc0_0104, 32'h1fc0_0104, 32'h1234_5678, 0, 1, 2'b00, 0, 0,
          1'b1, 1'b0, 32'h1234_5678);

    // Error response
`ifdef INST_AXI_ERR_EN
    fetch("slverr", 32'hbfc0_0200, 32'h1fc0_0200, 32'hcafe_f00d, 0, 0, 2'b10, 0, 0,
          1'b1, 1'b1, 32'h0000_0000);
`else
    fetch("slverr", 32'hbfc0_0200, 32'h1fc0_0200, 32'hcafe_f00d, 0, 0, 2'b10, 0, 0,
          1'b1, 1'b0, 32'hcafe_f00d);
`endif

    // Writes are never accepted
    inst_req = 1'b1;
    inst_wr  = 1'b1;
    #1;
    check("wr.addr_ok", {31'b0, inst_addr_ok}, 32'd0);
    step();
    check("wr.arvalid", {31'b0, arvalid}, 32'd0);
    inst_wr = 1'b0;

    // Cancel in IDLE blocks acceptance for that cycle only
    inst_cancel = 1'b1;
    #1;
    check("idle_cancel.addr_ok", {31'b0, inst_addr_ok}, 32'd0);
    step();
    check("idle_cancel.arvalid", {31'b0, arvalid}, 32'd0);
    inst_cancel = 1'b0;
    inst_req    = 1'b0;
    #1;

    // Asynchronous reset in the middle of DATA
    inst_req  = 1'b1;
    inst_addr = 32'hbfc0_0300;
    step();
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("mid.rready_pre", {31'b0, rready}, 32'd1);
    #2;
    rvalid = 1'b1;
    rdata  = 32'h5555_aaaa;
    rst    = 1'b1;
    #1;
    check("mid.arvalid", {31'b0, arvalid}, 32'd0);
    check("mid.rready", {31'b0, rready}, 32'd0);
    check("mid.addr_ok", {31'b0, inst_addr_ok}, 32'd0);
    check("mid.data_ok", {31'b0, inst_data_ok}, 32'd0);
    check("mid.rdata", inst_rdata, 32'd0);
    rvalid   = 1'b0;
    inst_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    fetch("post_rst", 32'hbfc0_0400, 32'h1fc0_0400, 32'h0bad_c0de, 0, 0, 2'b00, 0, 0,
          1'b1, 1'b0, 32'h0bad_c0de);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
